// File: rtl/jtpopeye_objsched.sv
// Per-line object scheduler: walks the object table once per scanline and
// presents one entry every two pixels. Optional in-zone cap: JTPOPEYE_OBJLIMIT_EN.
module jtpopeye_objsched #(
  parameter int OBJN   = 64,
  parameter int AW     = 6,
  parameter int MAXOBJ = 32
) (
  input  logic          rst_n,
  input  logic          clk,
  input  logic          pxl_cen,
  input  logic [7:0]    H,
  input  logic [7:0]    V,
  input  logic          VB,
  input  logic [28:0]   obj_data,
  output logic [AW-1:0] obj_addr,
  output logic [28:0]   DO,
  output logic          busy,
  output logic [7:0]    hit_cnt,
  output logic          ovf,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t        state, state_nx;
  logic [7:0]    idx, idx_nx;
  logic [AW-1:0] addr_nx;
  logic [28:0]   do_nx;
  logic [7:0]    hit_nx;
  logic          ovf_nx;
  logic [28:0]   null_entry;
  logic [7:0]    ysum;
  logic          in_zone;
  logic          gated;
  logic          line_start;

  // Y = 8 - V lands exactly at sum 8, just outside the zone for this line
  assign null_entry = {13'd0, 8'd8 - V, 8'd0};
  assign ysum       = obj_data[15:8] + V;
  assign in_zone    = (ysum[7:3] == 5'd0);
  assign line_start = (H == 8'hFE) && !VB;

`ifdef JTPOPEYE_OBJLIMIT_EN
  assign gated = in_zone && (hit_cnt == 8'(MAXOBJ));
`else
  assign gated = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    addr_nx  = obj_addr;
    do_nx    = DO;
    hit_nx   = hit_cnt;
    ovf_nx   = ovf;
    if (pxl_cen) begin
      if (line_start) begin
        state_nx = SCAN;
        idx_nx   = 8'd0;
        addr_nx  = '0;
        hit_nx   = 8'd0;
        ovf_nx   = 1'b0;
      end else if (state == SCAN && VB) begin
        state_nx = IDLE;
        do_nx    = null_entry;
      end else if (state == SCAN) begin
        // odd pixel: latch the entry so it is stable across the next even pixel
        if (H[0]) begin
          do_nx = gated ? null_entry : obj_data;
          if (in_zone && !gated && hit_cnt != 8'hFF) hit_nx = hit_cnt + 8'd1;
          if (gated) ovf_nx = 1'b1;
          if (idx == 8'(OBJN - 1)) begin
            state_nx = DONE;
          end else begin
            idx_nx  = idx + 8'd1;
            addr_nx = AW'(idx + 8'd1);
          end
        end
      end else if (H[0]) begin
        do_nx = null_entry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 8'd0;
      obj_addr <= '0;
      DO       <= 29'd0;
      hit_cnt  <= 8'd0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      obj_addr <= addr_nx;
      DO       <= do_nx;
      hit_cnt  <= hit_nx;
      ovf      <= ovf_nx;
    end
  end

  assign busy      = (state == SCAN);
  assign state_dbg = state;

endmodule

// File: tb/tb_jtpopeye_objsched.sv
// Directed bench for jtpopeye_objsched: table-driven scan checks plus
// hand-written VB, pixel-enable hold and mid-line reset sequences.
module tb_jtpopeye_objsched;

  logic        rst_n, clk, pxl_cen, VB;
  logic [7:0]  H, V;
  logic [28:0] obj_data;
  logic [5:0]  obj_addr;
  logic [28:0] DO;
  logic        busy, ovf;
  logic [7:0]  hit_cnt;
  logic [1:0]  state_dbg;

  logic [28:0] ram [64];
  int pass_cnt, total_cnt;

  localparam logic [1:0]  S_IDLE = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2;
  localparam logic [28:0] NUL10  = 29'h000FE00;  // null entry for V=10

  typedef struct {
    logic [7:0]  h;
    logic [28:0] dout;
    logic [5:0]  addr;
    logic        busy;
    logic [7:0]  hit;
    logic        ovf;
    logic [1:0]  st;
  } vec_t;

  vec_t tab_a [7];
  vec_t tab_b [4];

  jtpopeye_objsched #(.OBJN(64), .AW(6), .MAXOBJ(32)) dut (
    .rst_n(rst_n), .clk(clk), .pxl_cen(pxl_cen), .H(H), .V(V), .VB(VB),
    .obj_data(obj_data), .obj_addr(obj_addr), .DO(DO), .busy(busy),
    .hit_cnt(hit_cnt), .ovf(ovf), .state_dbg(state_dbg)
  );

  assign obj_data = ram[obj_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [28:0] ent(input int k, input logic [7:0] y);
    ent = {2'b00, 3'(k), 1'b0, 7'(k), y, 8'(k * 3)};
  endfunction

  task automatic fill(input logic [7:0] y_all, input int special, input logic [7:0] y_sp);
    for (int k = 0; k < 64; k++) ram[k] = ent(k, (k == special) ? y_sp : y_all);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (pxl_cen) H = H + 8'd1;
  endtask

  task automatic run_to(input logic [7:0] h);
    int n = 0;
    while (H !== h && n < 600) begin
      step();
      n++;
    end
    if (H !== h) begin
      total_cnt++;
      $display("FAIL run_to: H=%h never reached %h", H, h);
    end
  endtask

  task automatic check(input vec_t v, input string name);
    logic [47:0] act, exp;
    act = {DO, obj_addr, busy, hit_cnt, ovf, state_dbg};
    exp = {v.dout, v.addr, v.busy, v.hit, v.ovf, v.st};
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s H=%h: DO=%h addr=%0d busy=%b hit=%0d ovf=%b st=%0d, want DO=%h addr=%0d busy=%b hit=%0d ovf=%b st=%0d",
                  name, H, DO, obj_addr, busy, hit_cnt, ovf, state_dbg,
                  v.dout, v.addr, v.busy, v.hit, v.ovf, v.st);
  endtask

  function automatic vec_t mk(input logic [7:0] h, input logic [28:0] d, input logic [5:0] a,
                              input logic b, input logic [7:0] hc, input logic o, input logic [1:0] s);
    mk = '{h: h, dout: d, addr: a, busy: b, hit: hc, ovf: o, st: s};
  endfunction

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst_n = 1'b0; pxl_cen = 1'b1; VB = 1'b0; H = 8'hF0; V = 8'd10;
    fill(8'h40, 5, 8'hF8);

    // table A: one in-zone entry (5); table B: every entry in zone
    tab_a[0] = mk(8'hFF, NUL10,         6'd0,  1'b1, 8'd0, 1'b0, S_SCAN);
    tab_a[1] = mk(8'h00, ent(0, 8'h40), 6'd1,  1'b1, 8'd0, 1'b0, S_SCAN);
    tab_a[2] = mk(8'h01, ent(0, 8'h40), 6'd1,  1'b1, 8'd0, 1'b0, S_SCAN);
    tab_a[3] = mk(8'h0A, ent(5, 8'hF8), 6'd6,  1'b1, 8'd1, 1'b0, S_SCAN);
    tab_a[4] = mk(8'h0B, ent(5, 8'hF8), 6'd6,  1'b1, 8'd1, 1'b0, S_SCAN);
    tab_a[5] = mk(8'h7E, ent(63,8'h40), 6'd63, 1'b0, 8'd1, 1'b0, S_DONE);
    tab_a[6] = mk(8'h80, NUL10,         6'd63, 1'b0, 8'd1, 1'b0, S_DONE);

    tab_b[0] = mk(8'hFF, NUL10,         6'd0,  1'b1, 8'd0,  1'b0, S_SCAN);
    tab_b[1] = mk(8'h3F, ent(31,8'hF8), 6'd32, 1'b1, 8'd32, 1'b0, S_SCAN);
`ifdef JTPOPEYE_OBJLIMIT_EN
    tab_b[2] = mk(8'h40, NUL10,         6'd33, 1'b1, 8'd32, 1'b1, S_SCAN);
    tab_b[3] = mk(8'h80, NUL10,         6'd63, 1'b0, 8'd32, 1'b1, S_DONE);
`else
    tab_b[2] = mk(8'h40, ent(32,8'hF8), 6'd33, 1'b1, 8'd33, 1'b0, S_SCAN);
    tab_b[3] = mk(8'h80, NUL10,         6'd63, 1'b0, 8'd64, 1'b0, S_DONE);
`endif

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check(mk(8'hF0, 29'd0, 6'd0, 1'b0, 8'd0, 1'b0, S_IDLE), "reset");
    rst_n = 1'b1;

    // single in-zone entry, with a pixel-enable pause after H=01
    for (int i = 0; i < 7; i++) begin
      run_to(tab_a[i].h);
      check(tab_a[i], $sformatf("tab_a[%0d]", i));
      if (i == 2) begin
        pxl_cen = 1'b0;
        repeat (3) step();
        check(tab_a[2], "cen_hold");
        pxl_cen = 1'b1;
      end
    end

    // all entries in zone, then the following line start clears hit/ovf
    fill(8'hF8, -1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      run_to(tab_b[i].h);
      check(tab_b[i], $sformatf("tab_b[%0d]", i));
    end
    run_to(8'hFE);
    step();
    check(tab_b[0], "next_line_clear");

    // VB mid-scan aborts the line; no restart while VB is high
    fill(8'h40, 5, 8'hF8);
    run_to(8'hFE);
    run_to(8'h28);
    check(mk(8'h28, ent(20, 8'h40), 6'd21, 1'b1, 8'd1, 1'b0, S_SCAN), "pre_vb");
    VB = 1'b1;
    step();
    check(mk(8'h29, NUL10, 6'd21, 1'b0, 8'd1, 1'b0, S_IDLE), "vb_abort");
    run_to(8'h02);
    check(mk(8'h02, NUL10, 6'd21, 1'b0, 8'd1, 1'b0, S_IDLE), "vb_no_start");
    VB = 1'b0;
    run_to(8'hFF);
    check(mk(8'hFF, NUL10, 6'd0, 1'b1, 8'd0, 1'b0, S_SCAN), "vb_restart");

    // asynchronous reset mid-scan
    run_to(8'h32);
    check(mk(8'h32, ent(25, 8'h40), 6'd26, 1'b1, 8'd1, 1'b0, S_SCAN), "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    check(mk(8'h32, 29'd0, 6'd0, 1'b0, 8'd0, 1'b0, S_IDLE), "async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_to(8'h60);
    check(mk(8'h60, NUL10, 6'd0, 1'b0, 8'd0, 1'b0, S_IDLE), "post_rst_idle");
    run_to(8'h00);
    check(mk(8'h00, ent(0, 8'h40), 6'd1, 1'b1, 8'd0, 1'b0, S_SCAN), "post_rst_scan");
    run_to(8'h0A);
    check(mk(8'h0A, ent(5, 8'hF8), 6'd6, 1'b1, 8'd1, 1'b0, S_SCAN), "post_rst_hit");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
